// File: rtl/lfsr_rng_pkg.sv
// Shared types and defaults for the LFSR random-number scheduler.
package lfsr_rng_pkg;

   typedef enum logic [1:0] {
      StGenRst = 2'd0,
      StWarm   = 2'd1,
      StServe  = 2'd2,
      StLoad   = 2'd3
   } state_e;

   localparam int unsigned OutWDef     = 7;
   localparam int unsigned StateWDef   = 15;
   localparam logic [14:0] DefaultSeed = 15'h4A5B;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/lfsr_rng_sched.sv
// Shares one stochastic-rounding LFSR among NUM_REQ lanes: reset/warm-up, RR service, reseed.
// Optional grant counter output draw_cnt is enabled by defining RNG_STATS_EN.
module lfsr_rng_sched
   import lfsr_rng_pkg::*;
#(
   parameter int unsigned        NUM_REQ      = 4,
   parameter int unsigned        OUT_W        = OutWDef,
   parameter int unsigned        STATE_W      = StateWDef,
   parameter int unsigned        WARMUP       = 16,
   parameter logic [STATE_W-1:0] DEFAULT_SEED = STATE_W'(DefaultSeed)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rnd_valid,
   output logic [OUT_W-1:0]   rnd_data,
   input  logic               reseed_req,
   input  logic [STATE_W-1:0] reseed_val,
   output logic               reseed_busy,
   output logic               lfsr_rst,
   output logic [STATE_W-1:0] lfsr_rst_val,
   output logic               lfsr_prog,
   output logic [STATE_W-1:0] lfsr_seed,
   output logic               lfsr_en,
   input  logic [OUT_W-1:0]   lfsr_out
`ifdef RNG_STATS_EN
   ,
   output logic [15:0]        draw_cnt
`endif
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e             state_q, state_d;
   logic [7:0]         warm_cnt_q, warm_cnt_d;
   logic [IdxW-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               rnd_valid_q, rnd_valid_d;
   logic [OUT_W-1:0]   rnd_data_q, rnd_data_d;
   logic [STATE_W-1:0] lfsr_seed_q, lfsr_seed_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IdxW-1:0]    arb_idx;
   logic               arb_valid;
   logic               reseed_acc;
   logic               grant_go;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IdxW)
   ) u_rr_arbiter (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Reseed wins over any grant in the same cycle.
   assign reseed_acc = reseed_req && ((state_q == StServe) || (state_q == StWarm));
   assign grant_go   = (state_q == StServe) && arb_valid && !reseed_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StGenRst;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StGenRst: state_d = StWarm;
         StWarm: begin
            if (reseed_acc) begin
               state_d = StLoad;
            end else if (warm_cnt_q == 8'(WARMUP - 1)) begin
               state_d = StServe;
            end
         end
         StServe: begin
            if (reseed_acc) begin
               state_d = StLoad;
            end
         end
         StLoad:  state_d = StWarm;
         default: state_d = StGenRst;
      endcase
   end

   always_comb begin
      lfsr_rst    = (state_q == StGenRst);
      lfsr_prog   = (state_q == StLoad);
      lfsr_en     = ((state_q == StWarm) && !reseed_acc) || grant_go;
      reseed_busy = (state_q != StServe);
   end

   always_comb begin
      warm_cnt_d  = ((state_q == StWarm) && !reseed_acc) ? warm_cnt_q + 8'd1 : 8'd0;
      gnt_d       = grant_go ? arb_gnt : '0;
      rnd_valid_d = grant_go;
      rnd_data_d  = grant_go ? lfsr_out : rnd_data_q;
      ptr_d       = ptr_q;
      if (grant_go) begin
         ptr_d = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
      end
      lfsr_seed_d = lfsr_seed_q;
      // An all-zero state would lock the LFSR, so substitute the default seed.
      if (reseed_acc) begin
         lfsr_seed_d = (reseed_val == '0) ? DEFAULT_SEED : reseed_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         warm_cnt_q  <= 8'd0;
         ptr_q       <= '0;
         gnt_q       <= '0;
         rnd_valid_q <= 1'b0;
         rnd_data_q  <= '0;
         lfsr_seed_q <= DEFAULT_SEED;
      end else begin
         warm_cnt_q  <= warm_cnt_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         rnd_valid_q <= rnd_valid_d;
         rnd_data_q  <= rnd_data_d;
         lfsr_seed_q <= lfsr_seed_d;
      end
   end

   assign gnt          = gnt_q;
   assign rnd_valid    = rnd_valid_q;
   assign rnd_data     = rnd_data_q;
   assign lfsr_seed    = lfsr_seed_q;
   assign lfsr_rst_val = DEFAULT_SEED;

`ifdef RNG_STATS_EN
   logic [15:0] draw_cnt_q, draw_cnt_d;

   always_comb begin
      draw_cnt_d = draw_cnt_q;
      if (grant_go && (draw_cnt_q != 16'hFFFF)) begin
         draw_cnt_d = draw_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         draw_cnt_q <= 16'd0;
      end else begin
         draw_cnt_q <= draw_cnt_d;
      end
   end

   assign draw_cnt = draw_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// Directed bench for lfsr_rng_sched with a behavioural 15-bit LFSR generator.
module tb_lfsr_rng_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  gnt;
   logic        rnd_valid;
   logic [6:0]  rnd_data;
   logic        reseed_req;
   logic [14:0] reseed_val;
   logic        reseed_busy;
   logic        lfsr_rst;
   logic [14:0] lfsr_rst_val;
   logic        lfsr_prog;
   logic [14:0] lfsr_seed;
   logic        lfsr_en;
   logic [6:0]  lfsr_out;
`ifdef RNG_STATS_EN
   logic [15:0] draw_cnt;
`endif

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [14:0] gen_q  = 15'h0;
   logic [6:0]  last_out;
   logic [14:0] frozen;
   logic [3:0]  exp_gnt;

   always #5 clk = ~clk;

   // Generator model: x^15 + x^14 + 1 Fibonacci LFSR, low 7 bits as output.
   always @(posedge clk) begin
      if (lfsr_rst)       gen_q <= lfsr_rst_val;
      else if (lfsr_prog) gen_q <= lfsr_seed;
      else if (lfsr_en)   gen_q <= {gen_q[13:0], gen_q[14] ^ gen_q[13]};
   end
   assign lfsr_out = gen_q[6:0];

   lfsr_rng_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .gnt          (gnt),
      .rnd_valid    (rnd_valid),
      .rnd_data     (rnd_data),
      .reseed_req   (reseed_req),
      .reseed_val   (reseed_val),
      .reseed_busy  (reseed_busy),
      .lfsr_rst     (lfsr_rst),
      .lfsr_rst_val (lfsr_rst_val),
      .lfsr_prog    (lfsr_prog),
      .lfsr_seed    (lfsr_seed),
      .lfsr_en      (lfsr_en),
      .lfsr_out     (lfsr_out)
`ifdef RNG_STATS_EN
      ,
      .draw_cnt     (draw_cnt)
`endif
   );

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b0000; reseed_req = 1'b0; reseed_val = 15'h0;
      repeat (3) @(negedge clk);
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      n_chk++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
      n_chk++; if (rnd_data !== 7'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rnd_data); end
      n_chk++; if (lfsr_seed !== 15'h4A5B) begin n_fail++; $display("FAIL reset_seed: got %h want 4a5b", lfsr_seed); end
      n_chk++; if (lfsr_rst_val !== 15'h4A5B) begin n_fail++; $display("FAIL rst_val: got %h want 4a5b", lfsr_rst_val); end
`ifdef RNG_STATS_EN
      n_chk++; if (draw_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_draw_cnt: got %0d want 0", draw_cnt); end
`endif
      rst_n = 1'b1; req = 4'b1111; #1;
      n_chk++; if (lfsr_rst !== 1'b1 || lfsr_en !== 1'b0 || lfsr_prog !== 1'b0) begin
         n_fail++; $display("FAIL genrst_cycle: got rst=%b en=%b prog=%b want 1 0 0", lfsr_rst, lfsr_en, lfsr_prog);
      end
      for (int k = 2; k <= 17; k++) begin
         @(negedge clk); #1;
         n_chk++; if (lfsr_rst !== 1'b0 || lfsr_en !== 1'b1 || gnt !== 4'b0000 || reseed_busy !== 1'b1) begin
            n_fail++; $display("FAIL warm_cycle %0d: got rst=%b en=%b gnt=%b busy=%b want 0 1 0000 1",
                               k, lfsr_rst, lfsr_en, gnt, reseed_busy);
         end
      end
      @(negedge clk); #1;
      n_chk++; if (reseed_busy !== 1'b0 || gnt !== 4'b0000 || lfsr_en !== 1'b1) begin
         n_fail++; $display("FAIL first_serve: got busy=%b gnt=%b en=%b want 0 0000 1", reseed_busy, gnt, lfsr_en);
      end
      last_out = lfsr_out;
   endtask

   task automatic test_rr_all();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         exp_gnt = 4'b0001 << (k % 4);
         n_chk++; if (gnt !== exp_gnt || rnd_valid !== 1'b1) begin
            n_fail++; $display("FAIL rr_all_gnt %0d: got %b/%b want %b/1", k, gnt, rnd_valid, exp_gnt);
         end
         n_chk++; if (rnd_data !== last_out) begin
            n_fail++; $display("FAIL rr_all_data %0d: got %h want %h", k, rnd_data, last_out);
         end
         last_out = lfsr_out;
      end
`ifdef RNG_STATS_EN
      n_chk++; if (draw_cnt !== 16'd8) begin n_fail++; $display("FAIL draw_cnt_8: got %0d want 8", draw_cnt); end
`endif
      req = 4'b1010;
   endtask

   task automatic test_rr_sparse();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         exp_gnt = (k % 2 == 0) ? 4'b0010 : 4'b1000;
         n_chk++; if (gnt !== exp_gnt || rnd_valid !== 1'b1 || rnd_data !== last_out) begin
            n_fail++; $display("FAIL rr_sparse %0d: got gnt=%b v=%b d=%h want %b 1 %h",
                               k, gnt, rnd_valid, rnd_data, exp_gnt, last_out);
         end
         last_out = lfsr_out;
      end
      req = 4'b0000;
   endtask

   task automatic test_idle();
      @(negedge clk); #1;
      frozen = gen_q;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         n_chk++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || lfsr_en !== 1'b0 || gen_q !== frozen) begin
            n_fail++; $display("FAIL idle %0d: got gnt=%b v=%b en=%b gen=%h want 0000 0 0 %h",
                               k, gnt, rnd_valid, lfsr_en, gen_q, frozen);
         end
      end
   endtask

   task automatic test_reseed();
      reseed_req = 1'b1; reseed_val = 15'h1234; req = 4'b0001; #1;
      n_chk++; if (lfsr_en !== 1'b0) begin n_fail++; $display("FAIL reseed_en: got %b want 0", lfsr_en); end
      @(negedge clk); #1;
      n_chk++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reseed_nogrant: got gnt=%b v=%b want 0000 0", gnt, rnd_valid);
      end
      n_chk++; if (lfsr_prog !== 1'b1 || lfsr_rst !== 1'b0 || lfsr_en !== 1'b0 || lfsr_seed !== 15'h1234) begin
         n_fail++; $display("FAIL load_cycle: got prog=%b rst=%b en=%b seed=%h want 1 0 0 1234",
                            lfsr_prog, lfsr_rst, lfsr_en, lfsr_seed);
      end
      reseed_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin
            n_chk++; if (lfsr_out !== 7'h34) begin n_fail++; $display("FAIL seed_loaded: got %h want 34", lfsr_out); end
         end
         n_chk++; if (lfsr_en !== 1'b1 || lfsr_prog !== 1'b0 || gnt !== 4'b0000 || reseed_busy !== 1'b1) begin
            n_fail++; $display("FAIL reseed_warm %0d: got en=%b prog=%b gnt=%b busy=%b want 1 0 0000 1",
                               k, lfsr_en, lfsr_prog, gnt, reseed_busy);
         end
      end
      @(negedge clk); #1;
      n_chk++; if (reseed_busy !== 1'b0 || lfsr_en !== 1'b1 || gnt !== 4'b0000) begin
         n_fail++; $display("FAIL reseed_serve: got busy=%b en=%b gnt=%b want 0 1 0000", reseed_busy, lfsr_en, gnt);
      end
      last_out = lfsr_out;
      @(negedge clk); #1;
      n_chk++; if (gnt !== 4'b0001 || rnd_valid !== 1'b1 || rnd_data !== last_out) begin
         n_fail++; $display("FAIL reseed_grant: got gnt=%b v=%b d=%h want 0001 1 %h", gnt, rnd_valid, rnd_data, last_out);
      end
`ifdef RNG_STATS_EN
      n_chk++; if (draw_cnt !== 16'd15) begin n_fail++; $display("FAIL draw_cnt_15: got %0d want 15", draw_cnt); end
`endif
      req = 4'b0000;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req = 4'b0101; rst_n = 1'b0; #1;
      n_chk++; if (lfsr_en !== 1'b1) begin n_fail++; $display("FAIL mid_grant_due: got en=%b want 1", lfsr_en); end
      @(negedge clk); #1;
      n_chk++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || rnd_data !== 7'h00) begin
         n_fail++; $display("FAIL mid_reset_drop: got gnt=%b v=%b d=%h want 0000 0 00", gnt, rnd_valid, rnd_data);
      end
      n_chk++; if (lfsr_seed !== 15'h4A5B || lfsr_rst !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_state: got seed=%h rst=%b want 4a5b 1", lfsr_seed, lfsr_rst);
      end
`ifdef RNG_STATS_EN
      n_chk++; if (draw_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_draw_cnt: got %0d want 0", draw_cnt); end
`endif
      rst_n = 1'b1; #1;
      n_chk++; if (lfsr_rst !== 1'b1 || lfsr_en !== 1'b0) begin
         n_fail++; $display("FAIL mid_genrst: got rst=%b en=%b want 1 0", lfsr_rst, lfsr_en);
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         n_chk++; if (lfsr_rst !== 1'b0 || lfsr_en !== 1'b1 || gnt !== 4'b0000 || reseed_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_warm %0d: got rst=%b en=%b gnt=%b busy=%b want 0 1 0000 1",
                               k, lfsr_rst, lfsr_en, gnt, reseed_busy);
         end
      end
      @(negedge clk); #1;
      n_chk++; if (reseed_busy !== 1'b0) begin n_fail++; $display("FAIL mid_serve: got busy=%b want 0", reseed_busy); end
      last_out = lfsr_out;
      @(negedge clk); #1;
      n_chk++; if (gnt !== 4'b0001 || rnd_data !== last_out) begin
         n_fail++; $display("FAIL mid_ptr_reset: got gnt=%b d=%h want 0001 %h", gnt, rnd_data, last_out);
      end
      req = 4'b0000;
   endtask

   task automatic test_reseed_zero();
      @(negedge clk);
      reseed_req = 1'b1; reseed_val = 15'h0;
      @(negedge clk); #1;
      n_chk++; if (lfsr_prog !== 1'b1 || lfsr_seed !== 15'h4A5B) begin
         n_fail++; $display("FAIL zero_seed_sub: got prog=%b seed=%h want 1 4a5b", lfsr_prog, lfsr_seed);
      end
      reseed_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin
            n_chk++; if (lfsr_out !== 7'h5B) begin n_fail++; $display("FAIL zero_seed_loaded: got %h want 5b", lfsr_out); end
         end
      end
      @(negedge clk); #1;
      n_chk++; if (reseed_busy !== 1'b0 || gen_q === 15'h0) begin
         n_fail++; $display("FAIL zero_seed_warm: got busy=%b state=%h want 0 nonzero", reseed_busy, gen_q);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_rr_all();
      test_rr_sparse();
      test_idle();
      test_reseed();
      test_reset_mid();
      test_reseed_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_rng_sched.md
Name: lfsr_rng_sched

Overview:
Scheduler that shares one 15-bit-state / 7-bit-output stochastic-rounding LFSR generator among NUM_REQ rounding units.
- Sequences the generator: reset-value load, warm-up, then round-robin service, one fresh random value per grant.
- Handles run-time reseeding through the generator's prog/seed interface.
- Sits between the generator instance and the stochastic-rounding datapath lanes.

Parameters:
NUM_REQ, 4, number of requesting rounding lanes (2..8)
OUT_W, 7, generator output width
STATE_W, 15, generator state width
WARMUP, 16, enable cycles after reset/reseed before first grant (1..255)
DEFAULT_SEED, 15'h4A5B, rst_val driven to generator; also substitutes an all-zero reseed value

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-lane request for one random value (level, held until granted)
gnt  out  NUM_REQ  one-hot registered grant, 1-cycle pulse
rnd_valid  out  1  rnd_data valid, coincident with gnt
rnd_data  out  OUT_W  random value for the granted lane
reseed_req  in  1  reseed request (pulse or level)
reseed_val  in  STATE_W  new seed, sampled on acceptance
reseed_busy  out  1  high whenever state != SERVE
lfsr_rst  out  1  active-high sync reset to generator
lfsr_rst_val  out  STATE_W  constant DEFAULT_SEED
lfsr_prog  out  1  seed-load strobe to generator
lfsr_seed  out  STATE_W  registered seed to generator
lfsr_en  out  1  advance strobe to generator
lfsr_out  in  OUT_W  generator output

Behaviour:
- Interface decided: one clock clk; reset rst_n synchronous, active-low.
- FSM states: GEN_RST, WARM, SERVE, LOAD.
- Reset (rst_n=0 at edge): state=GEN_RST, gnt=0, rnd_valid=0, rnd_data=0, lfsr_seed=DEFAULT_SEED, warm counter=0, RR pointer=0 (lane 0 highest priority), draw_cnt=0.
- GEN_RST: lfsr_rst=1 for exactly 1 cycle -> WARM.
- WARM: lfsr_en=1 every cycle; counter counts 0..WARMUP-1 -> SERVE after WARMUP cycles; no grants.
- SERVE, grant cycle t with any req bit set and no reseed accepted:
  - winner = first set req at or after RR pointer, wrapping.
  - lfsr_en=1 combinationally in cycle t.
  - Edge t+1: gnt[winner]=1, rnd_valid=1, rnd_data=lfsr_out sampled at t; pointer=(winner+1) mod NUM_REQ.
  - Latency 1 cycle; max one grant per cycle; each value delivered once.
- SERVE, no req: lfsr_en=0, generator state frozen, gnt=0.
- Requester must drop req in the cycle gnt is seen. A req still high in that cycle counts as a new request and may be granted again under RR.
- Reseed acceptance:
  - Accepted when reseed_req=1 in SERVE or WARM.
  - Takes priority over grants that cycle: no grant and lfsr_en=0.
  - lfsr_seed <= reseed_val, or DEFAULT_SEED if reseed_val==0 (all-zero state locks the LFSR).
  - State -> LOAD.
- LOAD: lfsr_prog=1 for 1 cycle -> WARM with counter cleared. reseed_req is ignored in GEN_RST and LOAD, not queued.
- Outputs to generator:
  - lfsr_prog and lfsr_rst never assert together.
  - lfsr_en=0 whenever lfsr_rst or lfsr_prog is high.
- rst_n low mid-operation: any pending grant dropped (gnt/rnd_valid cleared at that edge), full GEN_RST/WARM sequence repeated.
- Single-lane (NUM_REQ=1): winner always lane 0, pointer stays 0.

Optional Feature:
RNG_STATS_EN:
- Defined: adds output draw_cnt [15:0], counting issued grants, saturating at 16'hFFFF, cleared by reset only (not by reseed).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package lfsr_rng_pkg: FSM state enum (GEN_RST, WARM, SERVE, LOAD), DEFAULT_SEED localparam, OUT_W/STATE_W defaults.
- Sub-module rr_arbiter: combinational NUM_REQ-wide round-robin pick from req + pointer, returning one-hot winner and index; pointer register stays in lfsr_rng_sched.

Test Plan:
- Reset release: lfsr_rst high for cycle 1 only, lfsr_en high for cycles 2..17 (WARMUP=16), reseed_busy low from cycle 18; gnt=0 throughout even with req=4'b1111.
- All four lanes request continuously: grants cycle lane 0,1,2,3,0,... one per cycle. Each rnd_data equals generator output of the previous cycle (compare against generator model).
- req=4'b1010 with pointer=0: lane 1 granted, then lane 3, then lane 1; lanes 0 and 2 never granted.
- reseed_req with reseed_val=15'h1234 and req=4'b0001 in the same cycle: no gnt that cycle. Next cycle lfsr_prog=1 with lfsr_seed=15'h1234, then 16 WARM cycles, then lane 0 granted.
- reseed_val=0: lfsr_seed=15'h4A5B on LOAD; generator output non-zero after warm-up.
- rst_n low for 1 cycle during SERVE with a grant due: gnt/rnd_valid 0 after that edge, GEN_RST sequence restarts. With RNG_STATS_EN: draw_cnt returns to 0 and saturates at 16'hFFFF after 65536+ grants.
